// File: rtl/bch_poly_pkg.sv
// Shared definitions for the key-equation polynomial coefficient bank:
// op encoding, load-FSM states and per-cell next-value select.
package bch_poly_pkg;

  localparam int unsigned M_DEFAULT     = 13;
  localparam int unsigned DEPTH_DEFAULT = 8;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_SHL  = 2'b01;
  localparam logic [1:0] OP_SHR  = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

  typedef enum logic [2:0] {
    CELL_HOLD = 3'd0,
    CELL_PAR  = 3'd1,
    CELL_SER  = 3'd2,
    CELL_NBR  = 3'd3,
    CELL_ZERO = 3'd4
  } cell_sel_e;

endpackage

// File: rtl/poly_coef_cell.sv
// One M-bit coefficient register with a next-value select
// (hold / parallel / serial / neighbour / zero).
module poly_coef_cell
  import bch_poly_pkg::*;
#(
  parameter int unsigned M = M_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  cell_sel_e    sel,
  input  logic [M-1:0] par_d,
  input  logic [M-1:0] ser_d,
  input  logic [M-1:0] nbr_d,
  output logic [M-1:0] q
);

  // Coefficient register: synchronous clear, otherwise the selected source.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      case (sel)
        CELL_PAR:  q <= par_d;
        CELL_SER:  q <= ser_d;
        CELL_NBR:  q <= nbr_d;
        CELL_ZERO: q <= '0;
        default:   q <= q;
      endcase
    end
  end

endmodule

// File: rtl/poly_coef_bank.sv
// poly_coef_bank: DEPTH-entry GF(2^M) polynomial coefficient bank with
// parallel/serial load, shift-up, shift-down, clear and sticky overflow.
// Optional macro POLY_DEGREE_EN adds deg / zero_poly outputs.
module poly_coef_bank
  import bch_poly_pkg::*;
#(
  parameter  int unsigned M     = M_DEFAULT,
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned DW    = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [M*DEPTH-1:0]   din_bus,
  input  logic                 ser_valid,
  input  logic [M-1:0]         ser_data,
  output logic                 ser_ready,
  input  logic                 op_en,
  input  logic [1:0]           op,
  output logic [M*DEPTH-1:0]   q_bus,
  output logic                 busy,
  output logic                 ser_done,
`ifdef POLY_DEGREE_EN
  output logic [DW-1:0]        deg,
  output logic                 zero_poly,
`endif
  output logic                 ovf
);

  state_e        state;
  logic [DW-1:0] cnt;
  logic          beat;
  logic [M-1:0]  coef [DEPTH];
  cell_sel_e     sel  [DEPTH];
  logic [M-1:0]  nbr  [DEPTH];

  assign ser_ready = !reset && !start;
  assign beat      = ser_valid && ser_ready;
  assign busy      = (state == ST_LOAD);

  // Coefficient cells plus their shift neighbours; edge cells shift in zero.
  for (genvar gi = 0; gi < int'(DEPTH); gi++) begin : g_cell
    logic [M-1:0] up_d;
    logic [M-1:0] dn_d;

    if (gi == 0) begin : g_up_edge
      assign up_d = '0;
    end else begin : g_up
      assign up_d = coef[gi-1];
    end

    if (gi == int'(DEPTH) - 1) begin : g_dn_edge
      assign dn_d = '0;
    end else begin : g_dn
      assign dn_d = coef[gi+1];
    end

    assign nbr[gi] = (op == OP_SHL) ? up_d : dn_d;
    assign q_bus[gi*M +: M] = coef[gi];

    poly_coef_cell #(.M(M)) u_cell (
      .clk   (clk),
      .reset (reset),
      .sel   (sel[gi]),
      .par_d (din_bus[gi*M +: M]),
      .ser_d (ser_data),
      .nbr_d (nbr[gi]),
      .q     (coef[gi])
    );
  end

  // Per-cell source select: start > serial beat > op (op only when idle).
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) sel[i] = CELL_HOLD;
    if (start) begin
      for (int unsigned i = 0; i < DEPTH; i++) sel[i] = CELL_PAR;
    end else if (beat) begin
      if (state == ST_IDLE) begin
        for (int unsigned i = 0; i < DEPTH; i++) sel[i] = (i == 0) ? CELL_SER : CELL_ZERO;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) sel[i] = (cnt == DW'(i)) ? CELL_SER : CELL_HOLD;
      end
    end else if (state == ST_IDLE && op_en) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        case (op)
          OP_SHL, OP_SHR: sel[i] = CELL_NBR;
          OP_CLR:         sel[i] = CELL_ZERO;
          default:        sel[i] = CELL_HOLD;
        endcase
      end
    end
  end

  // Serial-load FSM, beat counter, done pulse and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ser_done <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      ser_done <= 1'b0;
      if (start) begin
        state <= ST_IDLE;
        cnt   <= '0;
        ovf   <= 1'b0;
      end else if (beat) begin
        case (state)
          ST_IDLE: begin
            if (DEPTH == 1) begin
              ser_done <= 1'b1;
            end else begin
              state <= ST_LOAD;
              cnt   <= DW'(1);
            end
          end
          default: begin
            if (cnt == DW'(DEPTH - 1)) begin
              state    <= ST_IDLE;
              cnt      <= '0;
              ser_done <= 1'b1;
            end else begin
              cnt <= cnt + DW'(1);
            end
          end
        endcase
      end else if (state == ST_IDLE && op_en) begin
        if (op == OP_SHL)      ovf <= ovf | (coef[DEPTH-1] != '0);
        else if (op == OP_CLR) ovf <= 1'b0;
      end
    end
  end

`ifdef POLY_DEGREE_EN
  // Degree = index of highest nonzero coefficient; zero polynomial reports 0.
  always_comb begin
    deg       = '0;
    zero_poly = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (coef[i] != '0) begin
        deg       = DW'(i);
        zero_poly = 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_poly_coef_bank.sv
// Self-checking bench for poly_coef_bank: directed scenarios followed by
// randomized traffic, all checked against a coefficient-array reference model.
module tb_poly_coef_bank;
  import bch_poly_pkg::*;

  localparam int unsigned M     = 13;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned DW    = $clog2(DEPTH + 1);
  localparam int unsigned W     = M * DEPTH;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [W-1:0]  din_bus = '0;
  logic          ser_valid = 1'b0;
  logic [M-1:0]  ser_data = '0;
  logic          ser_ready;
  logic          op_en = 1'b0;
  logic [1:0]    op = OP_HOLD;
  logic [W-1:0]  q_bus;
  logic          busy;
  logic          ser_done;
  logic          ovf;
`ifdef POLY_DEGREE_EN
  logic [DW-1:0] deg;
  logic          zero_poly;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: plain coefficient array, load flag and next index.
  logic [M-1:0] mc [DEPTH];
  bit           mload = 0;
  int           midx  = 0;
  bit           mdone = 0;
  bit           movf  = 0;

  always #5 clk = ~clk;

  poly_coef_bank #(.M(M), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .din_bus   (din_bus),
    .ser_valid (ser_valid),
    .ser_data  (ser_data),
    .ser_ready (ser_ready),
    .op_en     (op_en),
    .op        (op),
    .q_bus     (q_bus),
    .busy      (busy),
    .ser_done  (ser_done),
`ifdef POLY_DEGREE_EN
    .deg       (deg),
    .zero_poly (zero_poly),
`endif
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_bus();
    logic [W-1:0] b;
    b = '0;
    for (int i = 0; i < int'(DEPTH); i++) b[i*M +: M] = mc[i];
    return b;
  endfunction

  // Apply one clock's worth of the bank's behavioural rules to the model.
  task automatic model_step();
    logic [M-1:0] old [DEPTH];
    mdone = 0;
    for (int i = 0; i < int'(DEPTH); i++) old[i] = mc[i];
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mc[i] = '0;
      mload = 0; midx = 0; movf = 0;
    end else if (start) begin
      for (int i = 0; i < int'(DEPTH); i++) mc[i] = din_bus[i*M +: M];
      mload = 0; midx = 0; movf = 0;
    end else if (ser_valid) begin
      if (!mload) begin
        for (int i = 0; i < int'(DEPTH); i++) mc[i] = '0;
        mc[0] = ser_data;
        midx = 1;
        mload = 1;
      end else begin
        mc[midx] = ser_data;
        midx++;
      end
      if (midx == int'(DEPTH)) begin
        mload = 0; midx = 0; mdone = 1;
      end
    end else if (!mload && op_en) begin
      case (op)
        OP_SHL: begin
          if (old[DEPTH-1] != '0) movf = 1;
          for (int i = 0; i < int'(DEPTH); i++) mc[i] = (i == 0) ? '0 : old[i-1];
        end
        OP_SHR: for (int i = 0; i < int'(DEPTH); i++) mc[i] = (i == int'(DEPTH) - 1) ? '0 : old[i+1];
        OP_CLR: begin
          for (int i = 0; i < int'(DEPTH); i++) mc[i] = '0;
          movf = 0;
        end
        default: ;
      endcase
    end
  endtask

  // Drive one cycle of inputs, advance the model and compare all outputs.
  task automatic cycle(input logic r, input logic s, input logic [W-1:0] d,
                       input logic v, input logic [M-1:0] sd,
                       input logic oe, input logic [1:0] o);
    int hi;
    @(negedge clk);
    reset = r; start = s; din_bus = d; ser_valid = v; ser_data = sd; op_en = oe; op = o;
    #1;
    check("ser_ready", 128'(ser_ready), 128'(!r && !s));
    @(posedge clk);
    model_step();
    #1;
    check("q_bus", 128'(q_bus), 128'(model_bus()));
    check("busy", 128'(busy), 128'(mload));
    check("ser_done", 128'(ser_done), 128'(mdone));
    check("ovf", 128'(ovf), 128'(movf));
`ifdef POLY_DEGREE_EN
    hi = 0;
    for (int i = 0; i < int'(DEPTH); i++) if (mc[i] != '0) hi = i;
    check("deg", 128'(deg), 128'(hi));
    check("zero_poly", 128'(zero_poly), 128'(model_bus() == '0));
`else
    hi = 0;
`endif
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, OP_HOLD);
  endtask

  task automatic beat(input logic [M-1:0] sd, input logic oe, input logic [1:0] o);
    cycle(1'b0, 1'b0, '0, 1'b1, sd, oe, o);
  endtask

  task automatic do_op(input logic [1:0] o);
    cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, o);
  endtask

  logic [W-1:0] bus;
  int           done_cnt;

  initial begin
    // Reset dominates a simultaneous start with nonzero data.
    bus = '0;
    for (int i = 0; i < int'(DEPTH); i++) bus[i*M +: M] = M'(16'h1F00 + i);
    cycle(1'b1, 1'b1, bus, 1'b0, '0, 1'b0, OP_HOLD);
    cycle(1'b1, 1'b1, bus, 1'b0, '0, 1'b0, OP_HOLD);
    check("rst_q_zero", 128'(q_bus), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_ovf", 128'(ovf), 128'(0));

    // Parallel load of 1..8.
    for (int i = 0; i < int'(DEPTH); i++) bus[i*M +: M] = M'(i + 1);
    cycle(1'b0, 1'b1, bus, 1'b0, '0, 1'b0, OP_HOLD);
    check("par_load", 128'(q_bus), 128'(bus));
    check("par_no_done", 128'(ser_done), 128'(0));

    // Serial load with a one-cycle gap after beat 3.
    done_cnt = 0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      beat(M'(16'h1A01 + i), 1'b0, OP_HOLD);
      if (i < int'(DEPTH) - 1) check("ser_busy_on", 128'(busy), 128'(1));
      if (ser_done) done_cnt++;
      if (i == 2) begin
        idle();
        check("ser_gap_busy", 128'(busy), 128'(1));
      end
    end
    check("ser_busy_off", 128'(busy), 128'(0));
    idle();
    if (ser_done) done_cnt++;
    check("ser_done_pulses", 128'(done_cnt), 128'(1));
    for (int i = 0; i < int'(DEPTH); i++) bus[i*M +: M] = M'(16'h1A01 + i);
    check("ser_result", 128'(q_bus), 128'(bus));

    // Shift-up drops a nonzero top coefficient -> ovf; clear resets it.
    for (int i = 0; i < int'(DEPTH); i++) bus[i*M +: M] = M'(16'h0100 + i);
    bus[(DEPTH-1)*M +: M] = M'(5);
    cycle(1'b0, 1'b1, bus, 1'b0, '0, 1'b0, OP_HOLD);
    do_op(OP_SHL);
    check("shl_c0", 128'(q_bus[M-1:0]), 128'(0));
    check("shl_c7", 128'(q_bus[(DEPTH-1)*M +: M]), 128'(16'h0106));
    check("shl_ovf", 128'(ovf), 128'(1));
    do_op(OP_CLR);
    check("clr_q", 128'(q_bus), 128'(0));
    check("clr_ovf", 128'(ovf), 128'(0));

    // Serial load with ops attempted while busy, then aborted by start.
    beat(M'(16'h0A01), 1'b1, OP_SHL);
    beat(M'(16'h0A02), 1'b1, OP_SHL);
    do_op(OP_SHL);
    check("op_ignored_busy", 128'(q_bus[2*M-1:0]), 128'({M'(16'h0A02), M'(16'h0A01)}));
    beat(M'(16'h0A03), 1'b1, OP_CLR);
    beat(M'(16'h0A04), 1'b0, OP_HOLD);
    for (int i = 0; i < int'(DEPTH); i++) bus[i*M +: M] = M'(16'h0777 - i);
    cycle(1'b0, 1'b1, bus, 1'b1, M'(16'h0A05), 1'b0, OP_HOLD);
    check("abort_q", 128'(q_bus), 128'(bus));
    check("abort_busy", 128'(busy), 128'(0));
    idle();
    check("abort_no_done", 128'(ser_done), 128'(0));

    // Degree scenario {0,3,0,7,0,0,0,0}.
    bus = '0;
    bus[1*M +: M] = M'(3);
    bus[3*M +: M] = M'(7);
    cycle(1'b0, 1'b1, bus, 1'b0, '0, 1'b0, OP_HOLD);
`ifdef POLY_DEGREE_EN
    check("deg3", 128'(deg), 128'(3));
    check("deg3_nz", 128'(zero_poly), 128'(0));
`endif
    do_op(OP_SHR);
`ifdef POLY_DEGREE_EN
    check("deg2", 128'(deg), 128'(2));
`endif
    do_op(OP_CLR);
`ifdef POLY_DEGREE_EN
    check("deg0", 128'(deg), 128'(0));
    check("deg0_z", 128'(zero_poly), 128'(1));
`endif

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic r, s, v, oe;
      logic [M-1:0] sd;
      logic [1:0] o;
      r  = ($urandom_range(0, 99) == 0);
      s  = ($urandom_range(0, 15) == 0);
      v  = ($urandom_range(0, 2) == 0);
      oe = ($urandom_range(0, 1) == 0);
      o  = 2'($urandom_range(0, 3));
      if (o == OP_CLR && $urandom_range(0, 3) != 0) o = OP_SHL;
      sd = ($urandom_range(0, 3) == 0) ? '0 : M'($urandom);
      for (int i = 0; i < int'(DEPTH); i++)
        bus[i*M +: M] = ($urandom_range(0, 2) == 0) ? '0 : M'($urandom);
      cycle(r, s, bus, v, sd, oe, o);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
